// File: rtl/uart_alu_interface.sv
// UART-to-ALU sequencer: collects operand A, operand B and an opcode from the
// receiver, latches the ALU result and hands it to the transmitter.
module uart_alu_interface #(
   parameter int unsigned NB_DATA  = 8,
   parameter int unsigned NB_OP    = 6,
   parameter int unsigned NB_STATE = 3
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rx_done_tick,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic [NB_DATA-1:0] i_alu_result,
   input  logic               i_tx_done_tick,
   output logic [NB_DATA-1:0] o_data_a,
   output logic [NB_DATA-1:0] o_data_b,
   output logic [NB_OP-1:0]   o_op,
   output logic               o_tx_start,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_busy,
   output logic               o_overrun
);

   localparam logic [NB_STATE-1:0] ST_WAIT_A    = NB_STATE'(0);
   localparam logic [NB_STATE-1:0] ST_WAIT_B    = NB_STATE'(1);
   localparam logic [NB_STATE-1:0] ST_WAIT_OP   = NB_STATE'(2);
   localparam logic [NB_STATE-1:0] ST_CALC      = NB_STATE'(3);
   localparam logic [NB_STATE-1:0] ST_SEND      = NB_STATE'(4);
   localparam logic [NB_STATE-1:0] ST_WAIT_DONE = NB_STATE'(5);

   logic [NB_STATE-1:0] state_q,    state_d;
   logic [NB_DATA-1:0]  data_a_q,   data_a_d;
   logic [NB_DATA-1:0]  data_b_q,   data_b_d;
   logic [NB_OP-1:0]    op_q,       op_d;
   logic [NB_DATA-1:0]  tx_data_q,  tx_data_d;
   logic                tx_start_q, tx_start_d;
   logic                overrun_q,  overrun_d;
   logic                busy_q,     busy_d;

   // Next-state and capture logic; bytes arriving while a result is in flight are dropped.
   always_comb begin
      state_d    = state_q;
      data_a_d   = data_a_q;
      data_b_d   = data_b_q;
      op_d       = op_q;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      overrun_d  = 1'b0;
      busy_d     = 1'b0;

      case (state_q)
         ST_WAIT_A: begin
            if (i_rx_done_tick) begin
               data_a_d = i_rx_data;
               state_d  = ST_WAIT_B;
            end
         end
         ST_WAIT_B: begin
            if (i_rx_done_tick) begin
               data_b_d = i_rx_data;
               state_d  = ST_WAIT_OP;
            end
         end
         ST_WAIT_OP: begin
            if (i_rx_done_tick) begin
               op_d    = i_rx_data[NB_OP-1:0];
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            overrun_d = i_rx_done_tick;
            tx_data_d = i_alu_result;
            state_d   = ST_SEND;
         end
         ST_SEND: begin
            overrun_d = i_rx_done_tick;
            state_d   = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            overrun_d = i_rx_done_tick;
            if (i_tx_done_tick) begin
               state_d = ST_WAIT_A;
            end
         end
         default: begin
            state_d = ST_WAIT_A;
         end
      endcase

      // Status flags are decoded from the upcoming state so they line up with it.
      tx_start_d = (state_d == ST_SEND);
      busy_d     = (state_d != ST_WAIT_A);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= ST_WAIT_A;
         data_a_q   <= '0;
         data_b_q   <= '0;
         op_q       <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         overrun_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_a_q   <= data_a_d;
         data_b_q   <= data_b_d;
         op_q       <= op_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         overrun_q  <= overrun_d;
         busy_q     <= busy_d;
      end
   end

   assign o_data_a   = data_a_q;
   assign o_data_b   = data_b_q;
   assign o_op       = op_q;
   assign o_tx_data  = tx_data_q;
   assign o_tx_start = tx_start_q;
   assign o_overrun  = overrun_q;
   assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for uart_alu_interface with a behavioural ALU.
module tb_uart_alu_interface;

   logic       clk;
   logic       i_reset;
   logic       i_rx_done_tick;
   logic [7:0] i_rx_data;
   logic [7:0] i_alu_result;
   logic       i_tx_done_tick;
   logic [7:0] o_data_a;
   logic [7:0] o_data_b;
   logic [5:0] o_op;
   logic       o_tx_start;
   logic [7:0] o_tx_data;
   logic       o_busy;
   logic       o_overrun;

   int checks   = 0;
   int failures = 0;
   int start_cnt = 0;
   int ovr_cnt   = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] opb;
      logic [5:0] exp_op;
      logic [7:0] exp_tx;
   } vec_t;

   vec_t vecs[6];

   uart_alu_interface #(.NB_DATA(8), .NB_OP(6), .NB_STATE(3)) dut (
      .i_clk          (clk),
      .i_reset        (i_reset),
      .i_rx_done_tick (i_rx_done_tick),
      .i_rx_data      (i_rx_data),
      .i_alu_result   (i_alu_result),
      .i_tx_done_tick (i_tx_done_tick),
      .o_data_a       (o_data_a),
      .o_data_b       (o_data_b),
      .o_op           (o_op),
      .o_tx_start     (o_tx_start),
      .o_tx_data      (o_tx_data),
      .o_busy         (o_busy),
      .o_overrun      (o_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Simple MIPS-flavoured ALU used both as the DUT's environment and as the reference.
   function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
      case (op)
         6'h20:   return 8'(a + b);
         6'h22:   return 8'(a - b);
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h27:   return ~(a | b);
         default: return a ^ {2'b00, op};
      endcase
   endfunction

   assign i_alu_result = alu_ref(o_data_a, o_data_b, o_op);

   // Pulse counters sampled away from the active edge.
   always @(negedge clk) begin
      if (o_tx_start) start_cnt++;
      if (o_overrun)  ovr_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_rx_data      = b;
      i_rx_done_tick = 1'b1;
      step();
      i_rx_done_tick = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_a"},       32'(o_data_a),   32'd0);
      chk({tag, "_b"},       32'(o_data_b),   32'd0);
      chk({tag, "_op"},      32'(o_op),       32'd0);
      chk({tag, "_tx_data"}, 32'(o_tx_data),  32'd0);
      chk({tag, "_start"},   32'(o_tx_start), 32'd0);
      chk({tag, "_ovr"},     32'(o_overrun),  32'd0);
      chk({tag, "_busy"},    32'(o_busy),     32'd0);
   endtask

   // One full transaction from the first WAIT_A cycle back to WAIT_A.
   task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                          input logic [5:0] exp_op, input logic [7:0] exp_tx,
                          input int extra, input int wait_cyc, input bit stray_tx,
                          input bit both_ticks);
      int s0;
      int o0;
      s0 = start_cnt;
      o0 = ovr_cnt;
      send_byte(a);
      chk("cap_a", 32'(o_data_a), 32'(a));
      chk("busy_after_a", 32'(o_busy), 32'd1);
      if (stray_tx) begin
         i_tx_done_tick = 1'b1;
         step();
         i_tx_done_tick = 1'b0;
         chk("stray_tx_busy", 32'(o_busy), 32'd1);
      end
      send_byte(b);
      chk("cap_b", 32'(o_data_b), 32'(b));
      send_byte(opb);
      chk("cap_op", 32'(o_op), 32'(exp_op));
      chk("start_early", 32'(o_tx_start), 32'd0);
      step();
      chk("start_t2", 32'(o_tx_start), 32'd1);
      chk("tx_data", 32'(o_tx_data), 32'(exp_tx));
      step();
      chk("start_width", 32'(o_tx_start), 32'd0);
      for (int i = 0; i < extra; i++) begin
         send_byte(8'($urandom));
         chk("ovr_pulse", 32'(o_overrun), 32'd1);
      end
      repeat (wait_cyc) step();
      chk("hold_regs", {o_data_a, o_data_b, 2'b00, o_op, o_tx_data},
          {a, b, 2'b00, exp_op, exp_tx});
      chk("busy_before_done", 32'(o_busy), 32'd1);
      i_tx_done_tick = 1'b1;
      if (both_ticks) begin
         i_rx_data      = 8'h5A;
         i_rx_done_tick = 1'b1;
      end
      step();
      i_tx_done_tick = 1'b0;
      i_rx_done_tick = 1'b0;
      chk("busy_after_done", 32'(o_busy), 32'd0);
      if (both_ticks) chk("ovr_both", 32'(o_overrun), 32'd1);
      step();
      chk("start_count", 32'(start_cnt - s0), 32'd1);
      chk("ovr_count", 32'(ovr_cnt - o0), 32'(extra + int'(both_ticks)));
   endtask

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [7:0] rop;

      vecs[0] = '{a: 8'h05, b: 8'h03, opb: 8'h20, exp_op: 6'h20, exp_tx: 8'h08};
      vecs[1] = '{a: 8'h05, b: 8'h03, opb: 8'hE4, exp_op: 6'h24, exp_tx: 8'h01};
      vecs[2] = '{a: 8'hF0, b: 8'h0F, opb: 8'h22, exp_op: 6'h22, exp_tx: 8'hE1};
      vecs[3] = '{a: 8'hAA, b: 8'h55, opb: 8'h26, exp_op: 6'h26, exp_tx: 8'hFF};
      vecs[4] = '{a: 8'h80, b: 8'h80, opb: 8'h20, exp_op: 6'h20, exp_tx: 8'h00};
      vecs[5] = '{a: 8'h0C, b: 8'h03, opb: 8'hA7, exp_op: 6'h27, exp_tx: 8'hF0};

      i_reset        = 1'b1;
      i_rx_done_tick = 1'b0;
      i_rx_data      = 8'h00;
      i_tx_done_tick = 1'b0;
      step();
      step();
      i_reset = 1'b0;
      chk_all_zero("reset");

      // Directed vectors, back to back; vector 1 also drops one byte in WAIT_DONE.
      for (int i = 0; i < 6; i++) begin
         run_txn(vecs[i].a, vecs[i].b, vecs[i].opb, vecs[i].exp_op, vecs[i].exp_tx,
                 (i == 1) ? 1 : 0, 2, 1'b0, 1'b0);
      end

      // Reset while waiting for operand B aborts the transaction.
      send_byte(8'h11);
      chk("pre_reset_a", 32'(o_data_a), 32'h11);
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      chk_all_zero("reset_wait_b");
      send_byte(8'h22);
      chk("post_reset_a", 32'(o_data_a), 32'h22);
      chk("post_reset_busy", 32'(o_busy), 32'd1);
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;

      // Simultaneous rx and tx done in WAIT_DONE, then a clean transaction.
      run_txn(8'h09, 8'h04, 8'h25, 6'h25, 8'h0D, 0, 1, 1'b0, 1'b1);
      run_txn(8'h01, 8'h02, 8'h20, 6'h20, 8'h03, 0, 0, 1'b0, 1'b0);

      // Randomized transactions checked against the reference ALU.
      for (int n = 0; n < 20; n++) begin
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         rop = 8'($urandom);
         if (n % 3 == 0) rop = {rop[7:6], 3'b100, rop[2:0]};
         run_txn(ra, rb, rop, rop[5:0], alu_ref(ra, rb, rop[5:0]),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
